rs232_ser: RTL and testbench
============================

# rs232_ser

RS-232 serializer: transmit half of the UART path. It pops bytes from an upstream transmit FIFO and shifts each one out on a single serial line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity, no flow control. It sits between the command/response logic's TX FIFO and the board UART pin, and mirrors the character framing of the receive deserializer.

## Interface
- P_CLK_FREQ_HZ, 100000000, clk frequency in Hz.
- P_BAUD_RATE, 9600, line rate in bit/s.
  - Derived constant: BIT_CYCLES = P_CLK_FREQ_HZ/P_BAUD_RATE, integer division. Requirement: BIT_CYCLES >= 4.
  - Bit counter width: ceil(log2(BIT_CYCLES+1)).

- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- tx_fifo_data  in  8  byte from the FIFO. Valid on the cycle after a read strobe (standard, non-show-ahead FIFO).
- tx_fifo_empty  in  1  FIFO empty flag.
- tx_fifo_rd_en  out  1  FIFO read strobe. Registered; exactly one cycle per byte.
- tx  out  1  serial line. Registered; idles high.
- tx_busy  out  1  high from the rd_en strobe through the last stop-bit cycle.

## Operation
The FSM has six states.
- S_IDLE
  - tx=1.
  - If tx_fifo_empty=0: set rd_en<=1 and busy<=1, go to S_REQ.
- S_REQ
  - rd_en<=0, go to S_LOAD.
  - This cycle is the FIFO's read cycle.
- S_LOAD
  - shreg<=tx_fifo_data, tx<=0, bit_cnt<=0, go to S_START.
- S_START
  - Hold tx=0 for BIT_CYCLES cycles.
  - At bit_cnt==BIT_CYCLES-1: tx<=shreg[0], shreg<=shreg>>1, shift_cnt<=0, bit_cnt<=0, go to S_SHIFT.
- S_SHIFT
  - Each data bit is held for BIT_CYCLES cycles.
  - At bit_cnt==BIT_CYCLES-1 with shift_cnt<7: output the next bit, shift_cnt+1.
  - At bit_cnt==BIT_CYCLES-1 with shift_cnt==7: tx<=1, go to S_STOP.
- S_STOP
  - tx=1 for BIT_CYCLES cycles.
  - At bit_cnt==BIT_CYCLES-1: busy<=0, go to S_IDLE.
- Illegal state code: go to S_IDLE next cycle with tx<=1.

General rules:
- The byte is captured once, in S_LOAD. Later changes on tx_fifo_data, or on tx_fifo_empty, have no effect on the frame in flight.
- rd_en is never asserted while tx_fifo_empty=1, and never while a frame is in progress.
- bit_cnt is reset to 0 on every bit boundary and never wraps past BIT_CYCLES-1.

## Timing
- Reset values: tx=1, tx_fifo_rd_en=0, tx_busy=0, shreg=0, bit_cnt=0, shift_cnt=0, fsm=S_IDLE.
- Reset mid-frame: on the first edge with rst_n=0, tx returns high and the partial byte is discarded. No rd_en is issued during reset.
- Latency: if tx_fifo_empty falls before edge E0, then:
  - rd_en is high during cycle E0..E1;
  - the start bit, tx=0, begins at edge E2.
- Frame length: exactly 10*BIT_CYCLES cycles from the tx falling edge to the end of the stop bit.
- Back-to-back bytes (FIFO stays non-empty): the next rd_en is issued on the first S_IDLE cycle.
  - Line high time between frames is BIT_CYCLES+3 cycles.
  - Frame period is 10*BIT_CYCLES+3 cycles.
- Bit rate error vs. nominal comes only from truncation in BIT_CYCLES. The bit period does not drift across a frame.
- tx_busy=0 for at least one cycle between frames (the S_IDLE cycle).

## Test plan
Benches use P_CLK_FREQ_HZ=1000000 and P_BAUD_RATE=100000, so BIT_CYCLES=10.
- Reset then idle, FIFO empty for 200 cycles -> tx=1, rd_en=0, busy=0 throughout.
- One byte 0xA5 -> exactly one rd_en pulse. tx then reads 0 (start), 1,0,1,0,0,1,0,1 (LSB first), 1 (stop), each level held exactly 10 cycles. busy falls after 100 cycles of frame.
- FIFO holds 0x00, 0xFF, 0x55 -> three frames. Each start falling edge is 103 cycles after the previous one. Decoded bytes are 0x00, 0xFF, 0x55. rd_en pulses are one cycle each and total 3.
- tx_fifo_data toggles randomly after the S_LOAD capture, and tx_fifo_empty asserts mid-frame -> transmitted byte equals the byte captured in S_LOAD. The frame completes, and no further rd_en is issued.
- rst_n low for 1 cycle during data bit 3 of 0x3C -> tx=1 on the next edge. No stop-bit glitch, no rd_en until the FIFO is non-empty after reset. The next byte 0x81 is sent correctly.
- Illegal-state force (fsm driven to an undefined code via force/release, if encoding permits) -> S_IDLE within 1 cycle, with tx=1.

Source files
------------

// File: rtl/rs232_ser.sv
// rs232_ser: 8N1 UART transmit serializer fed from a non-show-ahead TX FIFO.
// The FSM state type is in a small package so that it can be named from outside the module.

package rs232_ser_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_SHIFT = 3'd4,
    S_STOP  = 3'd5
  } state_t;
endpackage

module rs232_ser
  import rs232_ser_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ_HZ = 100000000,
  parameter int unsigned P_BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_fifo_data,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_rd_en,
  output logic       tx,
  output logic       tx_busy
);

  // Clock cycles per bit. The design relies on this being at least 4.
  localparam int unsigned BIT_CYCLES = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  state_t           state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       shift_cnt;
  logic             bit_last;

  // Last cycle of the current bit period
  assign bit_last = (bit_cnt == BIT_LAST);

  // Frame sequencer: FIFO handshake, bit timing and line driver
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tx            <= 1'b1;
      tx_fifo_rd_en <= 1'b0;
      tx_busy       <= 1'b0;
      shreg         <= 8'h00;
      bit_cnt       <= '0;
      shift_cnt     <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          tx            <= 1'b1;
          tx_fifo_rd_en <= 1'b0;
          if (!tx_fifo_empty) begin
            tx_fifo_rd_en <= 1'b1;
            tx_busy       <= 1'b1;
            state         <= S_REQ;
          end
        end
        // FIFO performs its read during this cycle
        S_REQ: begin
          tx_fifo_rd_en <= 1'b0;
          state         <= S_LOAD;
        end
        // Single capture point of the byte; start bit begins here
        S_LOAD: begin
          shreg   <= tx_fifo_data;
          tx      <= 1'b0;
          bit_cnt <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_last) begin
            tx        <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            shift_cnt <= 3'd0;
            bit_cnt   <= '0;
            state     <= S_SHIFT;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        // shift_cnt holds the index of the data bit currently on the line
        S_SHIFT: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (shift_cnt != 3'd7) begin
              tx        <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
              shift_cnt <= shift_cnt + 3'd1;
            end else begin
              tx    <= 1'b1;
              state <= S_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_last) begin
            tx_busy <= 1'b0;
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        // Unused state codes: drop the frame and return the line to idle
        default: begin
          state         <= S_IDLE;
          tx            <= 1'b1;
          tx_fifo_rd_en <= 1'b0;
          tx_busy       <= 1'b0;
          bit_cnt       <= '0;
          shift_cnt     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_ser.sv
// tb_rs232_ser: directed stimulus with a FIFO model and a scoreboard-driven line monitor.

module tb_rs232_ser;
  import rs232_ser_pkg::*;

  localparam int unsigned BC = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_empty;
  logic       tx_fifo_rd_en;
  logic       tx;
  logic       tx_busy;

  rs232_ser #(
    .P_CLK_FREQ_HZ(1000000),
    .P_BAUD_RATE  (100000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_fifo_data (tx_fifo_data),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_rd_en(tx_fifo_rd_en),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  int         rd_cnt       = 0;
  logic       rd_prev      = 1'b0;
  logic       load_pending = 1'b0;
  logic [7:0] load_byte    = 8'h00;

  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = 8'h00;
  int         mism       = 0;
  logic       abort      = 1'b0;
  logic       tx_prev    = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after the read strobe
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_prev      = 1'b0;
      load_pending = 1'b0;
    end else begin
      if (load_pending) begin
        tx_fifo_data = load_byte;
        load_pending = 1'b0;
      end
      if (tx_fifo_rd_en) begin
        chk("rd_en_width", int'(rd_prev), 0);
        if (!rd_prev) begin
          rd_cnt++;
          chk("rd_en_while_empty", int'(tx_fifo_empty), 0);
          chk("rd_en_during_frame", int'(mon_active), 0);
          if (fifo_q.size() > 0) begin
            load_byte    = fifo_q.pop_front();
            load_pending = 1'b1;
          end
          tx_fifo_empty = (fifo_q.size() == 0);
        end
      end
      rd_prev = tx_fifo_rd_en;
    end
  end

  function automatic logic exp_level(input int cnt, input logic [7:0] b);
    if (cnt < 10) return 1'b0;
    if (cnt < 90) return b[(cnt - 10) / 10];
    return 1'b1;
  endfunction

  // Line monitor: pops the expected byte at each start bit and checks every bit cycle
  always @(negedge clk) begin
    if (!rst_n || abort) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      mon_cnt++;
      if (mon_cnt < 100) begin
        if (tx !== exp_level(mon_cnt, mon_byte)) mism++;
        if (mon_cnt % 10 == 9) begin
          chk($sformatf("byte%02h_bit%0d_bad_cycles", mon_byte, mon_cnt / 10), mism, 0);
          mism = 0;
        end
        if (mon_cnt == 99) chk("busy_at_stop_end", int'(tx_busy), 1);
      end else begin
        chk("busy_after_frame", int'(tx_busy), 0);
        mon_active = 1'b0;
      end
    end else if (tx_prev && !tx) begin
      start_q.push_back(cyc);
      chk("frame_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_byte   = exp_q.pop_front();
        mon_active = 1'b1;
        mon_cnt    = 0;
        mism       = 0;
        chk("busy_at_start", int'(tx_busy), 1);
      end
    end
    tx_prev = tx;
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    fifo_q.push_back(b);
    tx_fifo_empty = 1'b0;
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic wait_start(input int maxc);
    int n0;
    int n;
    n0 = start_q.size();
    n  = 0;
    while (start_q.size() == n0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (start_q.size() == n0) chk("start_timeout", start_q.size() - n0, 1);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || mon_active || tx_busy) && n < maxc);
    if (exp_q.size() != 0 || mon_active || tx_busy)
      chk("drain_timeout", exp_q.size() + int'(mon_active) + int'(tx_busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0;
    int         s0;
    logic [2:0] st;

    rst_n         = 1'b0;
    tx_fifo_empty = 1'b1;
    tx_fifo_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_lines", int'({tx, tx_fifo_rd_en, tx_busy}), 3'b100);
    st = dut.state;
    chk("reset_state", int'(st), 0);
    rst_n = 1'b1;

    // Idle with an empty FIFO
    repeat (200) begin
      @(negedge clk);
      chk("idle_lines", int'({tx, tx_fifo_rd_en, tx_busy}), 3'b100);
    end

    // Single byte
    r0 = rd_cnt;
    push_byte(8'hA5, 1'b1);
    wait_done(400);
    chk("a5_rd_pulses", rd_cnt - r0, 1);

    // Back-to-back bytes
    r0 = rd_cnt;
    s0 = start_q.size();
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    wait_done(1000);
    chk("b2b_frames", start_q.size() - s0, 3);
    if (start_q.size() - s0 == 3) begin
      chk("b2b_gap1", start_q[s0 + 1] - start_q[s0], 10 * BC + 3);
      chk("b2b_gap2", start_q[s0 + 2] - start_q[s0 + 1], 10 * BC + 3);
    end
    chk("b2b_rd_pulses", rd_cnt - r0, 3);

    // Data toggling after capture; FIFO drained mid-frame
    r0 = rd_cnt;
    push_byte(8'hC3, 1'b1);
    push_byte(8'h99, 1'b0);
    wait_start(100);
    repeat (30) begin
      @(negedge clk);
      tx_fifo_data = 8'($urandom);
    end
    fifo_q.delete();
    tx_fifo_empty = 1'b1;
    repeat (40) begin
      @(negedge clk);
      tx_fifo_data = 8'($urandom);
    end
    wait_done(400);
    repeat (300) @(negedge clk);
    chk("drain_rd_pulses", rd_cnt - r0, 1);

    // Illegal state code mid-frame
    push_byte(8'h5A, 1'b1);
    wait_start(100);
    repeat (25) @(negedge clk);
    abort = 1'b1;
    force dut.state = state_t'(3'd7);
    @(negedge clk);
    chk("illegal_tx", int'(tx), 1);
    release dut.state;
    @(negedge clk);
    st = dut.state;
    chk("illegal_recover_state", int'(st), 0);
    chk("illegal_recover_lines", int'({tx, tx_fifo_rd_en, tx_busy}), 3'b100);
    abort = 1'b0;
    r0 = rd_cnt;
    push_byte(8'h96, 1'b1);
    wait_done(400);
    chk("after_illegal_rd_pulses", rd_cnt - r0, 1);

    // Reset during data bit 3
    push_byte(8'h3C, 1'b1);
    wait_start(100);
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_lines", int'({tx, tx_fifo_rd_en, tx_busy}), 3'b100);
    rst_n = 1'b1;
    r0 = rd_cnt;
    repeat (50) begin
      @(negedge clk);
      chk("post_reset_idle", int'({tx, tx_fifo_rd_en, tx_busy}), 3'b100);
    end
    push_byte(8'h81, 1'b1);
    wait_done(400);
    chk("post_reset_rd_pulses", rd_cnt - r0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
